// File: rtl/ofs_fim_pcie_ss_traffic_mon.sv
// Passive multi-channel AXI-S traffic monitor for the PCIe SS edges: per-channel
// saturating counters, sticky protocol errors and a timestamped SOP header trace.
module ofs_fim_pcie_ss_traffic_mon #(
    parameter int                NUM_CH        = 4,
    parameter int                HDR_W         = 256,
    parameter int                TRACE_DEPTH   = 64,
    parameter int                CNT_W         = 32,
    parameter logic [NUM_CH-1:0] HDR_ONLY_MASK = NUM_CH'(4'b1000),
    parameter int                TS_W          = 16,
    localparam int               SEL_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int               AW            = $clog2(TRACE_DEPTH),
    localparam int               ENT_W         = TS_W + 3 + HDR_W
) (
    input  logic                    fim_clk,
    input  logic                    fim_rst,
    input  logic [NUM_CH-1:0]       ch_tvalid,
    input  logic [NUM_CH-1:0]       ch_tready,
    input  logic [NUM_CH-1:0]       ch_tlast,
    input  logic [NUM_CH*HDR_W-1:0] ch_hdr,
    input  logic                    cnt_clr,
    input  logic                    trace_arm,
    input  logic                    freeze_on_err,
    input  logic [SEL_W-1:0]        sel_ch,
    output logic [CNT_W-1:0]        pkt_cnt,
    output logic [CNT_W-1:0]        beat_cnt,
    output logic [CNT_W-1:0]        drop_cnt,
    output logic [NUM_CH-1:0]       err_hdr_only,
    output logic [NUM_CH-1:0]       err_stable,
    input  logic [AW-1:0]           trace_rd_addr,
    output logic [ENT_W-1:0]        trace_rd_data,
    output logic [AW-1:0]           trace_wr_ptr,
    output logic [AW:0]             trace_count,
    output logic                    trace_frozen
);

    logic [NUM_CH-1:0] beat, sop, set_st, set_ho;
    logic [NUM_CH-1:0] sop_q, stall_q, last_q, err_ho_q, err_st_q;
    logic [HDR_W-1:0]  hdr_q  [NUM_CH];
    logic [CNT_W-1:0]  pkt_q  [NUM_CH];
    logic [CNT_W-1:0]  beat_q [NUM_CH];
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [CNT_W:0]    drop_sum;
    logic [TS_W-1:0]   ts_q;
    logic [AW-1:0]     wr_ptr_q;
    logic [AW:0]       count_q;
    logic              frozen_q;
    logic              win_vld, wr_en, new_err;
    logic [2:0]        win_idx;
    logic [3:0]        n_drop;
    logic [HDR_W-1:0]  win_hdr;
    logic [ENT_W-1:0]  mem [TRACE_DEPTH];
    logic [ENT_W-1:0]  rd_q;

    // A stalled beat must be re-presented unchanged on the following cycle.
    always_comb begin
        beat   = ch_tvalid & ch_tready;
        sop    = beat & sop_q;
        set_ho = beat & ~ch_tlast & HDR_ONLY_MASK;
        set_st = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            set_st[i] = stall_q[i] & (~ch_tvalid[i] | (ch_tlast[i] != last_q[i]) |
                        (ch_hdr[i*HDR_W +: HDR_W] != hdr_q[i]));
        end
    end

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        win_hdr = '0;
        n_drop  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sop[i]) begin
                if (!win_vld) begin
                    win_vld = 1'b1;
                    win_idx = 3'(i);
                    win_hdr = ch_hdr[i*HDR_W +: HDR_W];
                end else begin
                    n_drop = n_drop + 4'd1;
                end
            end
        end
    end

    always_comb begin
        wr_en    = win_vld & ~frozen_q & ~trace_arm;
        new_err  = (|((set_st & ~err_st_q) | (set_ho & ~err_ho_q))) & ~cnt_clr;
        drop_sum = {1'b0, drop_q} + (CNT_W+1)'(n_drop);
        if (cnt_clr)
            drop_d = '0;
        else if (!frozen_q && n_drop != 4'd0)
            drop_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        else
            drop_d = drop_q;
    end

    always_ff @(posedge fim_clk) begin
        if (fim_rst) begin
            sop_q    <= '1;
            stall_q  <= '0;
            last_q   <= '0;
            err_ho_q <= '0;
            err_st_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                pkt_q[i]  <= '0;
                beat_q[i] <= '0;
                hdr_q[i]  <= '0;
            end
        end else begin
            sop_q   <= (sop_q & ~beat) | (ch_tlast & beat);
            stall_q <= ch_tvalid & ~ch_tready;
            last_q  <= ch_tlast;
            for (int i = 0; i < NUM_CH; i++) begin
                hdr_q[i] <= ch_hdr[i*HDR_W +: HDR_W];
            end
            if (cnt_clr) begin
                err_ho_q <= '0;
                err_st_q <= '0;
                for (int i = 0; i < NUM_CH; i++) begin
                    pkt_q[i]  <= '0;
                    beat_q[i] <= '0;
                end
            end else begin
                err_ho_q <= err_ho_q | set_ho;
                err_st_q <= err_st_q | set_st;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (beat[i] && beat_q[i] != '1)
                        beat_q[i] <= beat_q[i] + CNT_W'(1);
                    if (beat[i] && ch_tlast[i] && pkt_q[i] != '1)
                        pkt_q[i] <= pkt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Arming takes priority over both a trace write and a freeze in the same cycle.
    always_ff @(posedge fim_clk) begin
        if (fim_rst) begin
            ts_q     <= '0;
            drop_q   <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            frozen_q <= 1'b0;
        end else begin
            ts_q   <= ts_q + TS_W'(1);
            drop_q <= drop_d;
            if (trace_arm) begin
                wr_ptr_q <= '0;
                count_q  <= '0;
                frozen_q <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                    if (count_q != (AW+1)'(TRACE_DEPTH))
                        count_q <= count_q + (AW+1)'(1);
                end
                if (freeze_on_err && new_err)
                    frozen_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge fim_clk) begin
        if (wr_en)
            mem[wr_ptr_q] <= {ts_q, win_idx, win_hdr};
    end

    always_ff @(posedge fim_clk) begin
        if (fim_rst)
            rd_q <= '0;
        else
            rd_q <= mem[trace_rd_addr];
    end

    always_comb begin
        pkt_cnt  = '0;
        beat_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (SEL_W'(i) == sel_ch) begin
                pkt_cnt  = pkt_q[i];
                beat_cnt = beat_q[i];
            end
        end
    end

    assign drop_cnt      = drop_q;
    assign err_hdr_only  = err_ho_q;
    assign err_stable    = err_st_q;
    assign trace_rd_data = rd_q;
    assign trace_wr_ptr  = wr_ptr_q;
    assign trace_count   = count_q;
    assign trace_frozen  = frozen_q;

endmodule

// File: tb/tb_ofs_fim_pcie_ss_traffic_mon.sv
// Bench for the PCIe SS traffic monitor: table-driven and hand-written sequences
// plus randomized traffic compared against a queue-based behavioural model.
module tb_ofs_fim_pcie_ss_traffic_mon;

    localparam int         NCH   = 4;
    localparam int         HW    = 32;
    localparam int         DEPTH = 64;
    localparam int         CW    = 4;
    localparam int         TW    = 16;
    localparam logic [3:0] MASK  = 4'b1000;
    localparam int         MAXC  = (1 << CW) - 1;
    localparam int         EW    = TW + 3 + HW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      valid = '0, ready = '1, last = '0;
    logic [HW-1:0]   hdr [NCH];
    logic [NCH*HW-1:0] chHdr;
    logic            cntClr = 1'b0, traceArm = 1'b0, freezeOnErr = 1'b0;
    logic [1:0]      selCh = '0;
    logic [5:0]      rdAddr = '0;
    logic [CW-1:0]   pktCnt, beatCnt, dropCnt;
    logic [3:0]      errHdrOnly, errStable;
    logic [EW-1:0]   traceRdData;
    logic [5:0]      traceWrPtr;
    logic [6:0]      traceCount;
    logic            traceFrozen;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int            num;
        logic [EW-1:0] data;
    } ent_t;

    int            mPkt [NCH];
    int            mBeat [NCH];
    int            mDrop, mTs, mWrites;
    bit [3:0]      mErrHo, mErrSt, mSop, mStall, mLast;
    logic [HW-1:0] mHdr [NCH];
    bit            mFrozen;
    ent_t          mTrace [$];

    typedef struct {
        logic [3:0]    valid;
        logic [3:0]    ready;
        logic [3:0]    last;
        logic [HW-1:0] hdr0;
        int            expPkt;
        int            expBeat;
    } vec_t;

    vec_t tbl [12];

    assign chHdr = {hdr[3], hdr[2], hdr[1], hdr[0]};

    always #10 clk = ~clk;

    ofs_fim_pcie_ss_traffic_mon #(
        .NUM_CH(NCH), .HDR_W(HW), .TRACE_DEPTH(DEPTH), .CNT_W(CW),
        .HDR_ONLY_MASK(MASK), .TS_W(TW)
    ) dut (
        .fim_clk(clk), .fim_rst(rst),
        .ch_tvalid(valid), .ch_tready(ready), .ch_tlast(last), .ch_hdr(chHdr),
        .cnt_clr(cntClr), .trace_arm(traceArm), .freeze_on_err(freezeOnErr),
        .sel_ch(selCh), .pkt_cnt(pktCnt), .beat_cnt(beatCnt), .drop_cnt(dropCnt),
        .err_hdr_only(errHdrOnly), .err_stable(errStable),
        .trace_rd_addr(rdAddr), .trace_rd_data(traceRdData),
        .trace_wr_ptr(traceWrPtr), .trace_count(traceCount), .trace_frozen(traceFrozen)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NCH; i++) begin
            mPkt[i]  = 0;
            mBeat[i] = 0;
            mHdr[i]  = '0;
        end
        mDrop = 0; mTs = 0; mWrites = 0;
        mErrHo = '0; mErrSt = '0; mSop = '1; mStall = '0; mLast = '0;
        mFrozen = 1'b0;
        mTrace.delete();
    endtask

    // Applies the spec rules to the inputs present at the clock edge.
    task automatic modelStep();
        bit [3:0] bt, sp, setSt, setHo;
        bit       newErr;
        int       win;
        ent_t     e;
        for (int i = 0; i < NCH; i++) begin
            bt[i]    = valid[i] && ready[i];
            sp[i]    = bt[i] && mSop[i];
            setSt[i] = mStall[i] && (!valid[i] || hdr[i] != mHdr[i] || last[i] != mLast[i]);
            setHo[i] = bt[i] && !last[i] && MASK[i];
        end
        newErr = !cntClr && (((setSt & ~mErrSt) | (setHo & ~mErrHo)) != 4'b0);
        win = -1;
        for (int i = NCH - 1; i >= 0; i--) if (sp[i]) win = i;
        if (!mFrozen && win >= 0) begin
            if (!traceArm) begin
                e.num  = mWrites;
                e.data = {mTs[TW-1:0], 3'(win), hdr[win]};
                mTrace.push_back(e);
                mWrites++;
                if (mTrace.size() > DEPTH) void'(mTrace.pop_front());
            end
            mDrop = sat(mDrop + $countones(sp) - 1);
        end
        if (cntClr) begin
            mDrop = 0; mErrHo = '0; mErrSt = '0;
            for (int i = 0; i < NCH; i++) begin
                mPkt[i]  = 0;
                mBeat[i] = 0;
            end
        end else begin
            mErrHo |= setHo;
            mErrSt |= setSt;
            for (int i = 0; i < NCH; i++) begin
                if (bt[i]) mBeat[i] = sat(mBeat[i] + 1);
                if (bt[i] && last[i]) mPkt[i] = sat(mPkt[i] + 1);
            end
        end
        if (traceArm) begin
            mFrozen = 1'b0;
            mTrace.delete();
            mWrites = 0;
        end else if (freezeOnErr && newErr) begin
            mFrozen = 1'b1;
        end
        for (int i = 0; i < NCH; i++) begin
            if (bt[i]) mSop[i] = last[i];
            mStall[i] = valid[i] && !ready[i];
            mHdr[i]   = hdr[i];
            mLast[i]  = last[i];
        end
        mTs = (mTs + 1) % (1 << TW);
    endtask

    task automatic checkAll();
        for (int c = 0; c < NCH; c++) begin
            selCh = 2'(c);
            #1;
            checkOutput($sformatf("pkt_cnt[%0d]", c), 64'(pktCnt), 64'(mPkt[c]));
            checkOutput($sformatf("beat_cnt[%0d]", c), 64'(beatCnt), 64'(mBeat[c]));
        end
        checkOutput("drop_cnt", 64'(dropCnt), 64'(mDrop));
        checkOutput("err_hdr_only", 64'(errHdrOnly), 64'(mErrHo));
        checkOutput("err_stable", 64'(errStable), 64'(mErrSt));
        checkOutput("trace_wr_ptr", 64'(traceWrPtr), 64'(mWrites % DEPTH));
        checkOutput("trace_count", 64'(traceCount), 64'(mTrace.size()));
        checkOutput("trace_frozen", 64'(traceFrozen), 64'(mFrozen));
    endtask

    // One clock: advance the model, then compare every output against it.
    task automatic tick();
        logic [63:0] expRd;
        bit          rdKnown;
        rdKnown = 1'b0;
        expRd   = '0;
        if (rst) rdKnown = 1'b1;
        else foreach (mTrace[k]) if (mTrace[k].num % DEPTH == int'(rdAddr)) begin
            rdKnown = 1'b1;
            expRd   = 64'(mTrace[k].data);
        end
        @(posedge clk);
        if (rst) modelReset(); else modelStep();
        #1;
        checkAll();
        if (rdKnown) checkOutput("trace_rd_data", 64'(traceRdData), expRd);
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic [3:0] r, input logic [3:0] l);
        valid = v;
        ready = r;
        last  = l;
        tick();
    endtask

    task automatic pulseClrArm();
        cntClr   = 1'b1;
        traceArm = 1'b1;
        applyStimulus(4'b0, 4'hF, 4'b0);
        cntClr   = 1'b0;
        traceArm = 1'b0;
    endtask

    task automatic readEntry(input int a, output logic [EW-1:0] d);
        rdAddr = 6'(a);
        applyStimulus(4'b0, 4'hF, 4'b0);
        d = traceRdData;
    endtask

    initial begin
        logic [EW-1:0] d0, d1;
        for (int i = 0; i < NCH; i++) hdr[i] = 32'h1000_0000 * (i + 1);
        for (int k = 0; k < 12; k++) begin
            tbl[k].valid   = 4'b0001;
            tbl[k].ready   = 4'b1111;
            tbl[k].last    = (k % 4 == 3) ? 4'b0001 : 4'b0000;
            tbl[k].hdr0    = 32'hA000_0000 + k;
            tbl[k].expBeat = k + 1;
            tbl[k].expPkt  = (k + 1) / 4;
        end

        // Reset state.
        rst = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        checkOutput("rst trace_rd_data", 64'(traceRdData), 64'd0);
        checkOutput("rst trace_count", 64'(traceCount), 64'd0);
        checkOutput("rst err_stable", 64'(errStable), 64'd0);
        rst = 1'b0;

        // Three 4-beat packets on ch0.
        for (int k = 0; k < 12; k++) begin
            hdr[0] = tbl[k].hdr0;
            applyStimulus(tbl[k].valid, tbl[k].ready, tbl[k].last);
            selCh = 2'd0;
            #1;
            checkOutput($sformatf("tbl%0d beat_cnt", k), 64'(beatCnt), 64'(tbl[k].expBeat));
            checkOutput($sformatf("tbl%0d pkt_cnt", k), 64'(pktCnt), 64'(tbl[k].expPkt));
        end
        checkOutput("ch0 trace_count", 64'(traceCount), 64'd3);
        readEntry(0, d0);
        readEntry(1, d1);
        checkOutput("ch0 entry0 idx", 64'(d0[HW+2:HW]), 64'd0);
        checkOutput("ch0 entry1 idx", 64'(d1[HW+2:HW]), 64'd0);
        checkOutput("ch0 ts delta", 64'(d1[EW-1:HW+3] - d0[EW-1:HW+3]), 64'd4);
        checkOutput("ch0 entry0 hdr", 64'(d0[HW-1:0]), 64'hA000_0000);

        // Header-only violation on ch3 freezes the trace after writing its SOP.
        pulseClrArm();
        freezeOnErr = 1'b1;
        hdr[3] = 32'h3333_0001;
        applyStimulus(4'b1000, 4'hF, 4'b0000);
        checkOutput("ho err_hdr_only", 64'(errHdrOnly), 64'h8);
        checkOutput("ho frozen", 64'(traceFrozen), 64'd1);
        applyStimulus(4'b1000, 4'hF, 4'b1000);
        applyStimulus(4'b0010, 4'hF, 4'b0010);
        applyStimulus(4'b0000, 4'hF, 4'b0000);
        checkOutput("ho trace_count", 64'(traceCount), 64'd1);
        checkOutput("ho drop_cnt", 64'(dropCnt), 64'd0);
        readEntry(0, d0);
        checkOutput("ho entry idx", 64'(d0[HW+2:HW]), 64'd3);
        freezeOnErr = 1'b0;

        // Simultaneous SOPs on ch1 and ch2.
        pulseClrArm();
        applyStimulus(4'b0110, 4'hF, 4'b0110);
        checkOutput("arb trace_count", 64'(traceCount), 64'd1);
        checkOutput("arb drop_cnt", 64'(dropCnt), 64'd1);
        readEntry(0, d0);
        checkOutput("arb entry idx", 64'(d0[HW+2:HW]), 64'd1);

        // ch2 drops tvalid while stalled, then cnt_clr coincides with a beat.
        applyStimulus(4'b0100, 4'b1011, 4'b0100);
        applyStimulus(4'b0000, 4'hF, 4'b0000);
        checkOutput("stab err_stable", 64'(errStable), 64'h4);
        cntClr = 1'b1;
        applyStimulus(4'b0100, 4'hF, 4'b0100);
        cntClr = 1'b0;
        checkOutput("clr err_stable", 64'(errStable), 64'd0);
        selCh = 2'd2;
        #1;
        checkOutput("clr beat_cnt[2]", 64'(beatCnt), 64'd0);

        // 70 single-beat packets wrap the trace; ch0 counters saturate.
        pulseClrArm();
        for (int k = 0; k < 70; k++) begin
            hdr[0] = 32'hB000_0000 + k;
            applyStimulus(4'b0001, 4'hF, 4'b0001);
        end
        checkOutput("wrap trace_count", 64'(traceCount), 64'd64);
        checkOutput("wrap trace_wr_ptr", 64'(traceWrPtr), 64'd6);
        selCh = 2'd0;
        #1;
        checkOutput("sat beat_cnt[0]", 64'(beatCnt), 64'd15);
        checkOutput("sat pkt_cnt[0]", 64'(pktCnt), 64'd15);
        readEntry(6, d0);
        checkOutput("wrap oldest hdr", 64'(d0[HW-1:0]), 64'hB000_0006);

        // Reset in mid-packet.
        applyStimulus(4'b0001, 4'hF, 4'b0000);
        rst = 1'b1;
        applyStimulus(4'b0000, 4'hF, 4'b0000);
        applyStimulus(4'b0000, 4'hF, 4'b0000);
        checkOutput("mid rst trace_count", 64'(traceCount), 64'd0);
        checkOutput("mid rst drop_cnt", 64'(dropCnt), 64'd0);
        checkOutput("mid rst beat_cnt", 64'(beatCnt), 64'd0);
        checkOutput("mid rst trace_rd_data", 64'(traceRdData), 64'd0);
        rst = 1'b0;
        applyStimulus(4'b0001, 4'hF, 4'b0001);
        checkOutput("post rst sop traced", 64'(traceCount), 64'd1);

        // Randomized traffic against the model.
        pulseClrArm();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NCH; i++) begin
                if (!(valid[i] && !ready[i] && $urandom_range(15) != 0)) begin
                    valid[i] = 1'($urandom_range(1));
                    last[i]  = ($urandom_range(2) != 0);
                    hdr[i]   = $urandom;
                end
                ready[i] = ($urandom_range(3) != 0);
            end
            cntClr   = ($urandom_range(63) == 0);
            traceArm = ($urandom_range(47) == 0);
            if (c % 200 == 0) freezeOnErr = 1'($urandom_range(1));
            rdAddr = 6'($urandom_range(63));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ofs_fim_pcie_ss_traffic_mon.md
Name: ofs_fim_pcie_ss_traffic_mon

Overview:
Synthesizable, parametrised multi-channel traffic monitor for PCIe SS AXI-S edges (RX, RXREQ, TX, TXREQ, or any subset). It passively observes the handshakes on each channel and tracks SOP per channel. It keeps saturating packet and beat counters per channel and flags protocol violations as sticky errors. SOP headers go into a timestamped ring-buffer trace that can freeze on error, so it can be read from hardware after the fact. It sits beside the PCIe SS wrapper and never drives any of the monitored channels.

Parameters:
NUM_CH, 4, number of monitored channels (1-8)
HDR_W, 256, low tdata bits captured per SOP (one PCIe SS header)
TRACE_DEPTH, 64, trace entries; must be a power of 2, range 4-1024
CNT_W, 32, width of the packet and beat counters
HDR_ONLY_MASK, 4'b1000, bit i set means channel i must carry only single-beat, header-only packets
TS_W, 16, timestamp width

Ports:
fim_clk  in  1  clock
fim_rst  in  1  synchronous, active-high reset
ch_tvalid  in  NUM_CH  per-channel tvalid
ch_tready  in  NUM_CH  per-channel tready
ch_tlast  in  NUM_CH  per-channel tlast
ch_hdr  in  NUM_CH*HDR_W  per-channel tdata[HDR_W-1:0]; channel i occupies slice i
cnt_clr  in  1  pulse; clears all counters and sticky errors
trace_arm  in  1  pulse; empties the trace and un-freezes it
freeze_on_err  in  1  level; when high, a new error freezes the trace
sel_ch  in  $clog2(NUM_CH) (minimum 1)  channel selected for counter readout
pkt_cnt  out  CNT_W  packets accepted on sel_ch
beat_cnt  out  CNT_W  beats accepted on sel_ch
drop_cnt  out  CNT_W  SOPs not traced because of arbitration loss
err_hdr_only  out  NUM_CH  sticky: a multi-beat packet was seen on a HDR_ONLY channel
err_stable  out  NUM_CH  sticky: AXI-S stability violated
trace_rd_addr  in  $clog2(TRACE_DEPTH)  trace read address
trace_rd_data  out  TS_W+3+HDR_W  {timestamp, ch_idx[2:0], hdr}; registered
trace_wr_ptr  out  $clog2(TRACE_DEPTH)  next write slot
trace_count  out  $clog2(TRACE_DEPTH)+1  number of valid entries
trace_frozen  out  1  trace is frozen

Behaviour:
- Beat: ch_tvalid[i] & ch_tready[i]. SOP: a beat taken while sop_q[i]=1.
- sop_q[i] resets to 1. On every beat, sop_q[i] takes the value of tlast.
- Counters: on each beat, beat_cnt[i] increments; on each beat with tlast, pkt_cnt[i] increments. Both saturate at all-ones.
- Stability check: if tvalid=1 and tready=0 in cycle n, then cycle n+1 must still have tvalid=1 with identical ch_hdr and tlast. Otherwise err_stable[i] sets.
- Header-only check: a beat with tlast=0 on a channel whose HDR_ONLY_MASK bit is set sets err_hdr_only[i].
- Errors are sticky and cleared only by cnt_clr or fim_rst.
- Trace timestamp: a free-running TS_W counter that wraps and resets to 0.
- Trace write: at most one write per cycle. When several SOPs occur in one cycle, the lowest index wins.
- drop_cnt adds the number of SOPs that lost arbitration and saturates.
- While trace_frozen=1, SOPs are not written and are not counted as drops.
- Each write stores {ts, i, ch_hdr slice i} at trace_wr_ptr. The pointer then increments modulo TRACE_DEPTH, so the trace overwrites its oldest entries. trace_count saturates at TRACE_DEPTH.
- Freeze: when freeze_on_err=1 and any error bit goes 0 to 1, trace_frozen=1 from the next cycle. An SOP beat that itself causes the error is written first.
- trace_arm clears wr_ptr, count and frozen in the next cycle. It wins over a write or freeze in the same cycle.
- cnt_clr wins over any increment or error set in the same cycle; that event is lost.
- Readout: pkt_cnt and beat_cnt are combinational muxes on sel_ch.
- trace_rd_data is a RAM read with 1-cycle latency. It is undefined until the addressed entry is written.
- Reset values: all counters 0, all errors 0, wr_ptr 0, count 0, frozen 0, sop_q all 1, ts 0, trace_rd_data 0.
- A reset in mid-packet returns sop_q to 1, so the next beat counts as an SOP.

Test Plan:
- ch0: 3 packets of 4 beats each, with tready always 1 -> pkt_cnt=3, beat_cnt=12, trace_count=3; entries carry ch_idx=0 with increasing timestamps.
- ch3 (HDR_ONLY): a 2-beat packet with freeze_on_err=1 -> err_hdr_only=4'b1000; the SOP is traced and trace_frozen=1 next cycle. Later SOPs on ch1 are not traced and drop_cnt stays 0.
- SOPs on ch1 and ch2 in the same cycle -> one entry with ch_idx=1 and drop_cnt=1.
- ch2 drops tvalid while tready=0 -> err_stable[2]=1. A later cnt_clr clears it; cnt_clr coincident with a beat leaves beat_cnt at 0.
- 70 single-beat packets with TRACE_DEPTH=64 -> trace_count=64 and trace_wr_ptr=6. Addr 6 holds the 7th packet, the oldest surviving entry.
- beat_cnt preset near saturation with CNT_W=4 -> it reaches 15 and holds. Reset asserted mid-packet -> all outputs return to 0 and the next beat is traced as an SOP.
